// File: rtl/vga_cursor_bank.sv
// Multi-channel hardware cursor register bank with vsync-synchronised
// shadow-to-active transfer, frame/blink counters and registered readback.
module vga_cursor_bank #(
    parameter int unsigned NUM_CURSORS = 2,
    parameter logic [11:0] BASE_ADDR   = 12'hE00,
    parameter int unsigned BLINK_DIV   = 16,
    parameter int unsigned SHADOW      = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_L,
    input  logic                     WREN,
    input  logic                     RDEN,
    input  logic [11:0]              Address,
    input  logic [7:0]               Data,
    input  logic                     vsync,
    output logic [8*NUM_CURSORS-1:0] ocrx,
    output logic [8*NUM_CURSORS-1:0] ocry,
    output logic [8*NUM_CURSORS-1:0] octl,
    output logic [NUM_CURSORS-1:0]   cursor_vis,
    output logic [7:0]               data_out
);
    typedef enum logic {INIT, IDLE} state_t;
    state_t state, state_next;

    logic [7:0] sh_ctl  [NUM_CURSORS];
    logic [7:0] sh_crx  [NUM_CURSORS];
    logic [7:0] sh_cry  [NUM_CURSORS];
    logic [7:0] act_ctl [NUM_CURSORS];
    logic [7:0] act_crx [NUM_CURSORS];
    logic [7:0] act_cry [NUM_CURSORS];

    logic       vsync_q, vs_rise, pending, blink_phase;
    logic [5:0] frame;
    logic [7:0] blink_cnt;

    logic [11:0] offset;
    logic [5:0]  ch;
    logic        ch_valid, is_ctl, is_crx, is_cry, is_status, wr_ok, rd_ok;
    logic [7:0]  rd_val;

    assign vs_rise   = vsync & ~vsync_q;
    assign offset    = Address - BASE_ADDR;
    assign ch        = offset[11:6];
    assign ch_valid  = 32'(ch) < NUM_CURSORS;
    assign is_ctl    = offset[5:0] == 6'h00;
    assign is_crx    = offset[5:0] == 6'h10;
    assign is_cry    = offset[5:0] == 6'h20;
    assign is_status = offset == 12'h030;
    assign wr_ok     = (state == IDLE) & WREN & ch_valid & (is_ctl | is_crx | is_cry);
    assign rd_ok     = (state == IDLE) & RDEN;

    always_ff @(posedge Clk) begin
        if (!Reset_L) state <= INIT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            INIT:    state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Active copies take the pre-write shadow on vs_rise, so a coincident
    // write lands in shadow only and waits for the next frame.
    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            for (int unsigned c = 0; c < NUM_CURSORS; c++) begin
                sh_ctl[c]  <= 8'hF2;
                sh_crx[c]  <= 8'h28;
                sh_cry[c]  <= 8'h14;
                act_ctl[c] <= 8'hF2;
                act_crx[c] <= 8'h28;
                act_cry[c] <= 8'h14;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CURSORS; c++) begin
                if (SHADOW != 0 && vs_rise) begin
                    act_ctl[c] <= sh_ctl[c];
                    act_crx[c] <= sh_crx[c];
                    act_cry[c] <= sh_cry[c];
                end
                if (wr_ok && ch == 6'(c)) begin
                    if (is_ctl) begin
                        sh_ctl[c] <= Data;
                        if (SHADOW == 0) act_ctl[c] <= Data;
                    end
                    if (is_crx) begin
                        sh_crx[c] <= Data;
                        if (SHADOW == 0) act_crx[c] <= Data;
                    end
                    if (is_cry) begin
                        sh_cry[c] <= Data;
                        if (SHADOW == 0) act_cry[c] <= Data;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            vsync_q     <= 1'b0;
            pending     <= 1'b0;
            frame       <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            data_out    <= '0;
        end else begin
            vsync_q <= vsync;
            if (SHADOW == 0)  pending <= 1'b0;
            else if (wr_ok)   pending <= 1'b1;
            else if (vs_rise) pending <= 1'b0;
            if (vs_rise) begin
                frame <= frame + 6'd1;
                if (blink_cnt == 8'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
            if (rd_ok) data_out <= rd_val;
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_status) begin
            rd_val = {frame, blink_phase, pending};
        end else if (ch_valid) begin
            for (int unsigned c = 0; c < NUM_CURSORS; c++) begin
                if (ch == 6'(c)) begin
                    if (is_ctl) rd_val = sh_ctl[c];
                    if (is_crx) rd_val = sh_crx[c];
                    if (is_cry) rd_val = sh_cry[c];
                end
            end
        end
    end

    always_comb begin
        ocrx       = '0;
        ocry       = '0;
        octl       = '0;
        cursor_vis = '0;
        for (int unsigned c = 0; c < NUM_CURSORS; c++) begin
            ocrx[8*c +: 8] = act_crx[c];
            ocry[8*c +: 8] = act_cry[c];
            octl[8*c +: 8] = act_ctl[c];
            cursor_vis[c]  = act_ctl[c][0] & (~act_ctl[c][1] | blink_phase);
        end
    end
endmodule
